// File: rtl/lud_byte_sequencer.sv
// Byte-serial front end for a 32-bit logical unit. It collects a 9-byte
// command (opcode, operand a, operand b), runs the unit for one cycle, and
// streams the 32-bit result back out LSB first.
module lud_byte_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [2:0]  lud_opt,
    output logic [31:0] lud_a,
    output logic [31:0] lud_b,
    input  logic [31:0] lud_ans,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] op_count
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OPT_W   = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned OPCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [OPT_W-1:0]    opt_q,       opt_d;
    logic [DATA_W-1:0]   a_q,         a_d;
    logic [DATA_W-1:0]   b_q,         b_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_data_q,  out_data_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [OPCNT_W-1:0]  op_count_q,  op_count_d;

    logic                in_acc;
    logic                out_acc;
    logic [CNT_W-1:0]    cnt_inc;

    // Handshakes and the next byte position within the current word
    always_comb begin
        in_acc  = in_valid && in_ready_q;
        out_acc = out_valid_q && out_ready;
        cnt_inc = cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic; outputs track the state being entered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opt_d      = opt_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        out_data_d = out_data_q;
        op_count_d = op_count_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    opt_d   = in_data[OPT_W-1:0];
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (in_acc) begin
                    a_d[{cnt_q, 3'b000} +: BYTE_W] = in_data;
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(3)) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (in_acc) begin
                    b_d[{cnt_q, 3'b000} +: BYTE_W] = in_data;
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(3)) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d   = lud_ans;
                out_data_d = lud_ans[BYTE_W-1:0];
                cnt_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (out_acc) begin
                    if (cnt_q == CNT_W'(3)) begin
                        cnt_d      = '0;
                        done_d     = 1'b1;
                        op_count_d = op_count_q + OPCNT_W'(1);
                        state_d    = IDLE;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_data_d = result_q[{cnt_inc, 3'b000} +: BYTE_W];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_ready_d  = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_B);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opt_q       <= opt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign lud_opt   = opt_q;
    assign lud_a     = a_q;
    assign lud_b     = b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_lud_byte_sequencer.sv
// Directed bench for lud_byte_sequencer with a behavioural logical unit.
module tb_lud_byte_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  lud_opt;
    logic [31:0] lud_a;
    logic [31:0] lud_b;
    logic [31:0] lud_ans;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    lud_byte_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lud_opt   (lud_opt),
        .lud_a     (lud_a),
        .lud_b     (lud_b),
        .lud_ans   (lud_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .op_count  (op_count)
    );

    // Behavioural logical unit
    function automatic logic [31:0] lu_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a ^ b;
            3'd2:    return ~(a & b);
            3'd3:    return a | b;
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a - b;
            default: return ~a;
        endcase
    endfunction

    assign lud_ans = lu_model(lud_opt, lud_a, lud_b);

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte (called at a negedge); returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int max_gap);
        send_byte(op, $urandom_range(0, max_gap));
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(0, max_gap));
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], $urandom_range(0, max_gap));
    endtask

    // Accept one result byte; returns at the negedge after acceptance
    task automatic recv_byte(input logic [7:0] exp, input string tag);
        int w;
        out_ready = 1'b1;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic recv_word(input logic [31:0] exp, input string tag);
        for (int i = 0; i < 4; i++) recv_byte(exp[8*i +: 8], $sformatf("%s_b%0d", tag, i));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_opt"},   32'(lud_opt), 32'd0);
        chk({tag, "_a"},     lud_a, 32'd0);
        chk({tag, "_b"},     lud_b, 32'd0);
        chk({tag, "_ovld"},  32'(out_valid), 32'd0);
        chk({tag, "_odata"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_opcnt"}, 32'(op_count), 32'd0);
        chk({tag, "_irdy"},  32'(in_ready), 32'd1);
    endtask

    initial begin
        int base;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst0");

        // AND
        base = done_cnt;
        send_cmd(8'h00, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        chk("and_a", lud_a, 32'hF0F0F0F0);
        chk("and_b", lud_b, 32'hFF00FF00);
        chk("and_opt", 32'(lud_opt), 32'd0);
        recv_word(32'hF000F000, "and");
        chk("and_done", 32'(done), 32'd1);
        chk("and_busy", 32'(busy), 32'd0);
        chk("and_opcnt", 32'(op_count), 32'd1);
        @(negedge clk);
        chk("and_done_low", 32'(done), 32'd0);
        chk("and_done_cnt", 32'(done_cnt - base), 32'd1);
        chk("and_hold_a", lud_a, 32'hF0F0F0F0);

        // Two's complement, latency check
        send_cmd(8'h06, 32'h00000000, 32'h00000001, 0);
        chk("tc_exec_busy", 32'(busy), 32'd1);
        chk("tc_exec_ovld", 32'(out_valid), 32'd0);
        chk("tc_exec_irdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("tc_ovld_n2", 32'(out_valid), 32'd1);
        recv_word(32'hFFFFFFFF, "tc");
        chk("tc_opcnt", 32'(op_count), 32'd2);

        // Ignored opcode bits and XOR
        send_cmd(8'hF9, 32'h12345678, 32'hFFFFFFFF, 0);
        chk("xor_opt", 32'(lud_opt), 32'd1);
        chk("xor_a", lud_a, 32'h12345678);
        recv_word(32'hEDCBA987, "xor");
        chk("xor_opcnt", 32'(op_count), 32'd3);

        // Backpressure and input gaps: XOR 11223344 ^ 0F0F0F0F = 1E2D3C4B
        send_cmd(8'h01, 32'h11223344, 32'h0F0F0F0F, 3);
        recv_byte(8'h4B, "bp_b0");
        recv_byte(8'h3C, "bp_b1");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), 32'(out_data), 32'h2D);
            chk($sformatf("bp_hold_vld%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_irdy%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        recv_byte(8'h2D, "bp_b2");
        recv_byte(8'h1E, "bp_b3");
        chk("bp_no_extra", 32'(out_valid), 32'd0);
        chk("bp_opcnt", 32'(op_count), 32'd4);

        // Reset after 6 bytes
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_byte(8'hEE, 0);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst1");
        send_cmd(8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        recv_word(32'h00000000, "nand");
        chk("nand_opcnt", 32'(op_count), 32'd1);

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        chk("wrap_pre", 32'(op_count), 32'h0000FFFF);
        send_cmd(8'h03, 32'h00000001, 32'h00000100, 1);
        recv_word(32'h00000101, "wrap");
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_opcnt", 32'(op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
